// File: rtl/router_pkg.sv
// router_pkg: shared defaults, header field positions and clog2 helper for the router datapath.
package router_pkg;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_MSB    = HDR_LEN_MSB;
  localparam int DEF_LEN_LSB    = HDR_LEN_LSB;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/router_fifo_ram.sv
// router_fifo_ram: unreset register array, one synchronous write port and one asynchronous read port.
module router_fifo_ram #(
  parameter int W     = 9,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware output FIFO; tags header words, tracks packet drain and reports errors.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int LEN_MSB    = DEF_LEN_MSB,
  parameter int LEN_LSB    = DEF_LEN_LSB,
  parameter int AF_MARGIN  = 2,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_reset,
  input  logic                  we,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [AW:0]           level,
  output logic                  pkt_busy,
  output logic                  pkt_last,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int CW = LEN_MSB - LEN_LSB + 2;
  localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - AF_MARGIN);
  logic [AW:0] wp, rp;
  logic [CW-1:0] rd_count;
  logic lfd_d, wr_ok, rd_ok;
  logic [DATA_WIDTH:0] rd_word;
  assign full        = wp == {~rp[AW], rp[AW-1:0]};
  assign empty       = wp == rp;
  assign level       = wp - rp;
  assign almost_full = level >= AF_LEVEL;
  assign pkt_busy    = rd_count != '0;
  assign wr_ok       = we && !full && !soft_reset;
  assign rd_ok       = re && !empty && !soft_reset;
  router_fifo_ram #(.W(DATA_WIDTH+1), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock(clock),
    .we(wr_ok),
    .waddr(wp[AW-1:0]),
    .wdata({lfd_d, data_in}),
    .raddr(rp[AW-1:0]),
    .rdata(rd_word)
  );
  // header word reloads the count with payload length plus the trailing parity byte
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      rd_count <= '0;
      lfd_d <= 1'b0;
      data_out <= '0;
      pkt_last <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (soft_reset) begin
      wp <= '0;
      rp <= '0;
      rd_count <= '0;
      lfd_d <= 1'b0;
      data_out <= '0;
      pkt_last <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      lfd_d <= lfd_state;
      if (wr_ok) wp <= wp + (AW+1)'(1);
      if (we && full) overflow <= 1'b1;
      if (re && empty) underflow <= 1'b1;
      pkt_last <= rd_ok && !rd_word[DATA_WIDTH] && rd_count == CW'(1);
      if (rd_ok) begin
        rp <= rp + (AW+1)'(1);
        data_out <= rd_word[DATA_WIDTH-1:0];
        rd_count <= rd_word[DATA_WIDTH] ? CW'(rd_word[LEN_MSB:LEN_LSB]) + CW'(1)
                  : pkt_busy ? rd_count - CW'(1) : rd_count;
      end else if (!pkt_busy) data_out <= '0;
    end
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo: randomized and directed checks of router_pkt_fifo against a queue-based model.
module tb_router_pkt_fifo;
  logic clock = 1'b0;
  logic reset, soft_reset, we, lfd_state, re;
  logic [7:0] data_in, data_out;
  logic full, empty, almost_full, pkt_busy, pkt_last, overflow, underflow;
  logic [4:0] level;
  int n_cmp = 0, n_bad = 0;
  logic [8:0] q[$];
  bit lfd_m, ovf_m, unf_m, last_m;
  int cnt;
  logic [7:0] dout_m;

  always #5 clock = ~clock;

  router_pkt_fifo dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset), .we(we), .lfd_state(lfd_state),
    .data_in(data_in), .re(re), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .level(level), .pkt_busy(pkt_busy), .pkt_last(pkt_last),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    lfd_m = 0; ovf_m = 0; unf_m = 0; last_m = 0; cnt = 0; dout_m = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".level"}, 32'(level), q.size());
    check({tag, ".full"}, 32'(full), 32'(q.size() == 16));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= 14));
    check({tag, ".data_out"}, 32'(data_out), 32'(dout_m));
    check({tag, ".pkt_busy"}, 32'(pkt_busy), 32'(cnt != 0));
    check({tag, ".rd_count"}, 32'(dut.rd_count), cnt);
    check({tag, ".pkt_last"}, 32'(pkt_last), 32'(last_m));
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
    check({tag, ".underflow"}, 32'(underflow), 32'(unf_m));
  endtask

  task automatic step(input string tag, input bit w, input bit l, input bit r,
                      input logic [7:0] d, input bit sr = 1'b0);
    bit rd, wr;
    logic [8:0] word;
    we = w; lfd_state = l; re = r; data_in = d; soft_reset = sr;
    if (sr) model_clear();
    else begin
      if (w && q.size() == 16) ovf_m = 1;
      if (r && q.size() == 0) unf_m = 1;
      rd = r && q.size() != 0;
      wr = w && q.size() != 16;
      last_m = 0;
      if (rd) begin
        word = q.pop_front();
        dout_m = word[7:0];
        if (word[8]) cnt = int'(word[7:2]) + 1;
        else if (cnt != 0) begin
          last_m = (cnt == 1);
          cnt--;
        end
      end else if (cnt == 0) dout_m = '0;
      if (wr) q.push_back({lfd_m, d});
      lfd_m = l;
    end
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1; soft_reset = 0; we = 0; lfd_state = 0; re = 0; data_in = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    reset = 0;
    step("idle", 0, 0, 0, 8'h00);
    // one full packet: header len 3, three payload bytes, parity
    step("lfd", 0, 1, 0, 8'h00);
    step("hdr", 1, 0, 0, 8'h0C);
    step("p0", 1, 0, 0, 8'hA1);
    step("p1", 1, 0, 0, 8'hA2);
    step("p2", 1, 0, 0, 8'hA3);
    step("par", 1, 0, 0, 8'h5F);
    for (int i = 0; i < 5; i++) step("pkt_rd", 0, 0, 1, 8'h00);
    check("pkt_last_seen", 32'(pkt_last), 32'd1);
    check("pkt_dout_par", 32'(data_out), 32'h5F);
    step("pkt_idle", 0, 0, 0, 8'h00);
    for (int i = 0; i < 17; i++) step("fill", 1, 0, 0, 8'($urandom));
    check("full_ovf", 32'(overflow), 32'd1);
    step("full_we_re", 1, 0, 1, 8'hEE);
    check("full_we_re_lvl", 32'(level), 32'd15);
    while (q.size() != 0) step("drain", 0, 0, 1, 8'h00);
    step("empty_we_re", 1, 0, 1, 8'h77);
    check("empty_we_re_unf", 32'(underflow), 32'd1);
    step("sr_clear", 0, 0, 0, 8'h00, 1'b1);
    // random traffic with occasional headers; well over two pointer wraps
    for (int i = 0; i < 160; i++)
      step("rand", $urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0,
           $urandom_range(1, 0) == 1, 8'($urandom));
    while (q.size() != 0) step("rdrain", 0, 0, 1, 8'h00);
    step("rdrain_idle", 0, 0, 1, 8'h00);
    step("sr_clear2", 0, 0, 0, 8'h00, 1'b1);
    // soft reset mid-packet: header len 5 plus 10 words, then 4 reads
    step("lfd2", 0, 1, 0, 8'h00);
    step("hdr2", 1, 0, 0, 8'h14);
    for (int i = 0; i < 10; i++) step("pay2", 1, 0, 0, 8'(i + 1));
    for (int i = 0; i < 4; i++) step("rd2", 0, 0, 1, 8'h00);
    check("mid_level", 32'(level), 32'd7);
    check("mid_count", 32'(dut.rd_count), 32'd3);
    step("soft_reset", 1, 1, 1, 8'hCC, 1'b1);
    for (int i = 0; i < 3; i++) step("refill", 1, 0, 0, 8'(8'h40 + i));
    @(negedge clock);
    reset = 1;
    #1;
    model_clear();
    check_all("async_reset");
    @(posedge clock);
    #1;
    check_all("reset_hold");
    reset = 0;
    step("post_reset", 1, 0, 0, 8'h99);
    step("post_reset_rd", 0, 0, 1, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
